// File: rtl/bp_history_index.sv
// Global-history index generator and in-order in-flight branch tracker feeding the 2-bit counter table.
// Define BP_GHR_EN for gshare indexing (PC XOR GHR); leave it undefined for bimodal indexing (PC only).
module bp_history_index #(
   parameter int BPRED_WIDTH = 9,
   parameter int HIST_WIDTH  = 9,
   parameter int DEPTH       = 4
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic [31:0]            i_PC,
   input  logic                   i_Predict_Valid,
   input  logic                   i_Prediction,
   output logic [BPRED_WIDTH-1:0] o_Index,
   output logic                   o_Full,
   input  logic                   i_Resolve_Valid,
   input  logic                   i_Resolve_Outcome,
   output logic                   o_Branch_Valid,
   output logic [BPRED_WIDTH-1:0] o_Resolution_Index,
   output logic                   o_Branch_Outcome,
   output logic                   o_Mispredict
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [BPRED_WIDTH-1:0] idxMem_q [DEPTH];
   logic [DEPTH-1:0]       predMem_q;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic                   branchValid_q;
   logic [BPRED_WIDTH-1:0] resolutionIndex_q;
   logic                   branchOutcome_q;
   logic                   mispredict_q;

   logic                   resolveFire;
   logic                   mispredict;
   logic                   allocFire;
   logic [HIST_WIDTH-1:0]  ghr;
   logic [BPRED_WIDTH-1:0] ghrExt;
   logic                   unusedPcBits;

   assign unusedPcBits = ^{i_PC[31:BPRED_WIDTH+2], i_PC[1:0]};

`ifdef BP_GHR_EN
   logic [HIST_WIDTH-1:0] snapMem_q [DEPTH];
   logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

   function automatic logic [HIST_WIDTH-1:0] shiftIn(input logic [HIST_WIDTH-1:0] hist,
                                                     input logic newBit);
      logic [HIST_WIDTH:0] wide;
      wide = {hist, newBit};
      return wide[HIST_WIDTH-1:0];
   endfunction

   // Recovery rebuilds history from the mispredicted branch's snapshot plus its real direction.
   always_comb begin
      ghr_d = ghr_q;
      if (mispredict) begin
         ghr_d = shiftIn(snapMem_q[head_q], i_Resolve_Outcome);
      end else if (allocFire) begin
         ghr_d = shiftIn(ghr_q, i_Prediction);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (allocFire) begin
         snapMem_q[tail_q] <= ghr_q;
      end
   end

   assign ghr = ghr_q;
`else
   assign ghr = '0;
`endif

   always_comb begin
      ghrExt = '0;
      ghrExt[HIST_WIDTH-1:0] = ghr;
   end

   assign o_Index = i_PC[BPRED_WIDTH+1:2] ^ ghrExt;
   assign o_Full  = (count_q == FULL_CNT);

   // A correct resolve frees the head slot in the same edge, so a full queue can still accept a branch.
   assign resolveFire = i_Resolve_Valid && (count_q != '0);
   assign mispredict  = resolveFire && (predMem_q[head_q] != i_Resolve_Outcome);
   assign allocFire   = i_Predict_Valid && !mispredict && (!o_Full || resolveFire);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (mispredict) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (resolveFire) begin
            head_d = head_q + PTR_W'(1);
         end
         if (allocFire) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (allocFire && !resolveFire) begin
            count_d = count_q + CNT_W'(1);
         end else if (!allocFire && resolveFire) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (allocFire) begin
         idxMem_q[tail_q]  <= o_Index;
         predMem_q[tail_q] <= i_Prediction;
      end
   end

   // Update port pulses for one cycle per resolve; index and outcome hold between pulses.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         branchValid_q     <= 1'b0;
         resolutionIndex_q <= '0;
         branchOutcome_q   <= 1'b0;
         mispredict_q      <= 1'b0;
      end else begin
         branchValid_q <= resolveFire;
         mispredict_q  <= mispredict;
         if (resolveFire) begin
            resolutionIndex_q <= idxMem_q[head_q];
            branchOutcome_q   <= i_Resolve_Outcome;
         end
      end
   end

   assign o_Branch_Valid     = branchValid_q;
   assign o_Resolution_Index = resolutionIndex_q;
   assign o_Branch_Outcome   = branchOutcome_q;
   assign o_Mispredict       = mispredict_q;

endmodule

// File: tb/tb_bp_history_index.sv
// Randomized and directed bench for bp_history_index, checked against a queue-based reference model.
// Honours BP_GHR_EN the same way as the design (gshare when defined, bimodal otherwise).
module tb_bp_history_index;

   localparam int BPRED_WIDTH = 9;
   localparam int HIST_WIDTH  = 9;
   localparam int DEPTH       = 4;

   logic                   clk;
   logic                   i_Reset;
   logic [31:0]            i_PC;
   logic                   i_Predict_Valid;
   logic                   i_Prediction;
   logic [BPRED_WIDTH-1:0] o_Index;
   logic                   o_Full;
   logic                   i_Resolve_Valid;
   logic                   i_Resolve_Outcome;
   logic                   o_Branch_Valid;
   logic [BPRED_WIDTH-1:0] o_Resolution_Index;
   logic                   o_Branch_Outcome;
   logic                   o_Mispredict;

   bp_history_index #(
      .BPRED_WIDTH(BPRED_WIDTH),
      .HIST_WIDTH (HIST_WIDTH),
      .DEPTH      (DEPTH)
   ) dut (
      .i_Clk             (clk),
      .i_Reset           (i_Reset),
      .i_PC              (i_PC),
      .i_Predict_Valid   (i_Predict_Valid),
      .i_Prediction      (i_Prediction),
      .o_Index           (o_Index),
      .o_Full            (o_Full),
      .i_Resolve_Valid   (i_Resolve_Valid),
      .i_Resolve_Outcome (i_Resolve_Outcome),
      .o_Branch_Valid    (o_Branch_Valid),
      .o_Resolution_Index(o_Resolution_Index),
      .o_Branch_Outcome  (o_Branch_Outcome),
      .o_Mispredict      (o_Mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit pred;
      int snap;
   } entry_t;

   entry_t modelQ[$];
   int     modelGhr;
   bit     expValid;
   int     expResIdx;
   bit     expOutcome;
   bit     expMispredict;
   int     checks;
   int     errors;

   // History as a plain integer: shift left, insert newest direction, keep HIST_WIDTH bits.
   function automatic int historyAfter(input int hist, input bit newBit);
`ifdef BP_GHR_EN
      return ((hist << 1) | int'(newBit)) & ((1 << HIST_WIDTH) - 1);
`else
      return 0 & hist & int'(newBit);
`endif
   endfunction

   function automatic int indexFor(input logic [31:0] pc, input int hist);
      return (int'(pc >> 2) & ((1 << BPRED_WIDTH) - 1)) ^ hist;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model past the edge.
   task automatic applyStimulus(input bit rst, input logic [31:0] pc, input bit pv, input bit pred,
                                input bit rv, input bit outc);
      bit     doResolve;
      bit     wrong;
      entry_t head;
      entry_t fresh;
      @(negedge clk);
      i_Reset           = rst;
      i_PC              = pc;
      i_Predict_Valid   = pv;
      i_Prediction      = pred;
      i_Resolve_Valid   = rv;
      i_Resolve_Outcome = outc;
      #1;
      checkOutput("index", 32'(o_Index), 32'(indexFor(pc, modelGhr)));
      checkOutput("full", 32'(o_Full), 32'(modelQ.size() == DEPTH));
      checkOutput("branchValid", 32'(o_Branch_Valid), 32'(expValid));
      checkOutput("resIndex", 32'(o_Resolution_Index), 32'(expResIdx));
      checkOutput("outcome", 32'(o_Branch_Outcome), 32'(expOutcome));
      checkOutput("mispredict", 32'(o_Mispredict), 32'(expMispredict));

      if (rst) begin
         modelQ.delete();
         modelGhr      = 0;
         expValid      = 1'b0;
         expResIdx     = 0;
         expOutcome    = 1'b0;
         expMispredict = 1'b0;
      end else begin
         doResolve = rv && (modelQ.size() > 0);
         wrong     = 1'b0;
         expValid  = doResolve;
         if (doResolve) begin
            head          = modelQ.pop_front();
            wrong         = (head.pred != outc);
            expResIdx     = head.idx;
            expOutcome    = outc;
         end
         expMispredict = wrong;
         if (wrong) begin
            modelQ.delete();
            modelGhr = historyAfter(head.snap, outc);
         end else if (pv && modelQ.size() < DEPTH) begin
            fresh.idx  = indexFor(pc, modelGhr);
            fresh.pred = pred;
            fresh.snap = modelGhr;
            modelQ.push_back(fresh);
            modelGhr = historyAfter(modelGhr, pred);
         end
      end
   endtask

   localparam logic [31:0] PC10 = 32'h0000_0010;

   initial begin
      checks            = 0;
      errors            = 0;
      i_Reset           = 1'b1;
      i_PC              = PC10;
      i_Predict_Valid   = 1'b0;
      i_Prediction      = 1'b0;
      i_Resolve_Valid   = 1'b0;
      i_Resolve_Outcome = 1'b0;
      modelGhr          = 0;
      expValid          = 1'b0;
      expResIdx         = 0;
      expOutcome        = 1'b0;
      expMispredict     = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state and allocate pair.
      applyStimulus(1, PC10, 0, 0, 0, 0);
      checkOutput("tpResetIndex", 32'(o_Index), 32'h004);
      applyStimulus(0, PC10, 1, 1, 0, 0);
      applyStimulus(0, PC10, 1, 0, 0, 0);
      applyStimulus(0, PC10, 0, 0, 0, 0);
`ifdef BP_GHR_EN
      checkOutput("tpGhrIndex", 32'(o_Index), 32'h006);
`else
      checkOutput("tpBimodalIndex", 32'(o_Index), 32'h004);
`endif
      // Correct resolve of the first branch.
      applyStimulus(0, PC10, 0, 0, 1, 1);
      applyStimulus(0, PC10, 0, 0, 0, 0);
      checkOutput("tpResolveValid", 32'(o_Branch_Valid), 32'h1);
      checkOutput("tpResolveIndex", 32'(o_Resolution_Index), 32'h004);
      applyStimulus(0, PC10, 0, 0, 0, 0);

      // Three taken predictions, head mispredicted.
      applyStimulus(1, PC10, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, PC10, 1, 1, 0, 0);
      applyStimulus(0, PC10, 0, 0, 1, 0);
      applyStimulus(0, PC10, 0, 0, 0, 0);
      checkOutput("tpMispredict", 32'(o_Mispredict), 32'h1);
      checkOutput("tpRecoveredIndex", 32'(o_Index), 32'h004);

      // Fill, overflow, then resolve and allocate together while full.
      repeat (4) applyStimulus(0, PC10, 1, 1, 0, 0);
      applyStimulus(0, 32'h0000_0104, 1, 0, 0, 0);
      applyStimulus(0, 32'h0000_0208, 1, 1, 1, 1);
      applyStimulus(0, PC10, 0, 0, 0, 0);
      checkOutput("tpFullHolds", 32'(o_Full), 32'h1);

      // Resolve on empty, then reset with a resolve in flight and coincident with one.
      applyStimulus(1, PC10, 0, 0, 0, 0);
      applyStimulus(0, PC10, 0, 0, 1, 1);
      applyStimulus(0, PC10, 1, 0, 0, 0);
      applyStimulus(0, PC10, 0, 0, 1, 1);
      applyStimulus(1, PC10, 0, 0, 0, 0);
      applyStimulus(0, PC10, 1, 1, 0, 0);
      applyStimulus(1, PC10, 0, 0, 1, 0);
      applyStimulus(0, PC10, 0, 0, 0, 0);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0), $urandom(),
                       ($urandom_range(0, 9) < 6), 1'($urandom()),
                       ($urandom_range(0, 9) < 4), 1'($urandom()));
      end
      applyStimulus(0, PC10, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_history_index.md
# bp_history_index

Global-history index generator and in-flight branch tracker sitting directly upstream of the 2-bit counter table in the branch predictor. At fetch it hashes the PC with a speculative global history register (GHR) to form the counter-table read index, and records each predicted branch in a small in-order queue. When the ALU resolves a branch, it drives the counter-table update port (valid, index, outcome), flags mispredictions and repairs the GHR.

## Interface
- BPRED_WIDTH, 9, counter-table index width
- HIST_WIDTH, 9, GHR width; legal range 1..BPRED_WIDTH
- DEPTH, 4, in-flight branch queue entries; power of two, ≥2

- i_Clk  in  1  clock; all state updates on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_PC  in  32  fetch PC of the current branch
- i_Predict_Valid  in  1  a branch is being predicted this cycle; allocate an entry
- i_Prediction  in  1  counter-table prediction for o_Index (1 = taken)
- o_Index  out  BPRED_WIDTH  counter-table read index (combinational)
- o_Full  out  1  queue holds DEPTH entries
- i_Resolve_Valid  in  1  ALU resolved the oldest in-flight branch
- i_Resolve_Outcome  in  1  actual direction (1 = taken)
- o_Branch_Valid  out  1  counter-table update enable
- o_Resolution_Index  out  BPRED_WIDTH  counter to update
- o_Branch_Outcome  out  1  direction written to the counter
- o_Mispredict  out  1  resolved direction differed from stored prediction

## Operation
- o_Index = i_PC[BPRED_WIDTH+1:2] XOR zero-extended GHR.
- Allocate (i_Predict_Valid & ~o_Full & no mispredict this edge): push {o_Index, i_Prediction, GHR}; GHR <= {GHR[HIST_WIDTH-2:0], i_Prediction} (HIST_WIDTH=1: GHR <= i_Prediction).
- Allocate while full: ignored; queue and GHR unchanged.
- Resolve (i_Resolve_Valid & queue non-empty): pop head; register o_Branch_Valid=1, o_Resolution_Index=head index, o_Branch_Outcome=i_Resolve_Outcome, o_Mispredict=(head prediction != outcome).
- Resolve on empty queue: ignored; no update pulse, o_Mispredict stays 0.
- Mispredict recovery, same edge: GHR <= {head snapshot[HIST_WIDTH-2:0], i_Resolve_Outcome}; queue emptied (younger entries are wrong-path); any simultaneous allocate is dropped.
- Correct resolve with simultaneous allocate: both take effect; occupancy unchanged; GHR shifts with i_Prediction.
- Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH distinguishes full from empty.

## Timing
- Reset: GHR=0, queue empty, o_Full=0, o_Branch_Valid=0, o_Resolution_Index=0, o_Branch_Outcome=0, o_Mispredict=0. o_Index = PC bits only.
- o_Index: zero-latency combinational from i_PC and current GHR.
- Update outputs: registered, valid the cycle after the resolving edge, high exactly one cycle per resolve; 0 otherwise (index/outcome hold last value).
- GHR effect of allocate or recovery visible on o_Index the cycle after the edge.
- o_Full: combinational from occupancy; updates the cycle after the edge.
- Reset asserted mid-operation: at that edge all state and outputs return to reset values; in-flight update pulse suppressed.

## Configuration
- BP_GHR_EN defined: behaviour as above (gshare).
- BP_GHR_EN undefined: GHR held constant 0 and not stored per entry; o_Index = i_PC[BPRED_WIDTH+1:2] (bimodal). Queue, update port and o_Mispredict unchanged; recovery only flushes the queue.

## Test plan
- Reset, i_PC=0x00000010 -> o_Index=0x004, o_Full=0, o_Branch_Valid=0, o_Mispredict=0.
- Allocate PC=0x10 pred=1, then PC=0x10 pred=0 -> o_Index 0x004, then 0x005; after second edge GHR=0b10, o_Index=0x006.
- Resolve head with outcome=1 (predicted 1) -> next cycle o_Branch_Valid=1 for one cycle, o_Resolution_Index=0x004, o_Branch_Outcome=1, o_Mispredict=0.
- Three allocates (preds 1,1,1 from GHR=0), resolve head with outcome=0 -> o_Mispredict=1, index 0x004; queue empty; GHR=0b0 so o_Index for PC=0x10 returns 0x004.
- Fill DEPTH=4 entries -> o_Full=1; fifth allocate ignored (GHR unchanged); resolve + allocate same edge with correct prediction -> o_Full stays 1.
- Resolve on empty queue -> no o_Branch_Valid pulse; assert i_Reset while a resolve is in flight -> outputs all 0 next cycle.
